// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU priority with a bounded win streak so the accelerator
// cannot starve. Optional statistics counters under DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_wren,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_data,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_q,
  output logic              acc_rvalid,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       conflict_count,
  output logic [15:0]       forced_count,
`endif
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_ACC  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [3:0] streak_q;
  logic [3:0] streak_d;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;

  logic both_req;
  logic streak_full;
  logic cpu_granted;
  logic acc_granted;

  // Grant decision: CPU wins unless it has used up its contended streak
  always_comb begin
    both_req    = cpu_req & acc_req;
    streak_full = (streak_q == STREAK_MAX);
    cpu_granted = cpu_req & ~(acc_req & streak_full);
    acc_granted = acc_req & ~cpu_granted;
  end

  assign cpu_stall = cpu_req & ~cpu_granted;
  assign acc_gnt   = acc_req & acc_granted;

  // RAM port mux; idle port is driven to all zeros
  always_comb begin
    mem_wren = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (cpu_granted) begin
      mem_wren = cpu_wren;
      mem_addr = cpu_addr;
      mem_data = cpu_data;
    end else if (acc_granted) begin
      mem_wren = acc_wren;
      mem_addr = acc_addr;
      mem_data = acc_data;
    end
  end

  // Next streak and read-return owner
  always_comb begin
    streak_d = streak_q;
    if (both_req & cpu_granted) begin
      streak_d = streak_q + 4'd1;
    end else if (acc_granted | ~acc_req) begin
      streak_d = 4'd0;
    end
    rd_owner_d = OWN_NONE;
    if (cpu_granted & ~cpu_wren) begin
      rd_owner_d = OWN_CPU;
    end else if (acc_granted & ~acc_wren) begin
      rd_owner_d = OWN_ACC;
    end
  end

  // Streak counter and read owner tag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak_q   <= 4'd0;
      rd_owner_q <= OWN_NONE;
    end else begin
      streak_q   <= streak_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_q      = mem_q;
  assign acc_q      = mem_q;
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign acc_rvalid = (rd_owner_q == OWN_ACC);

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q;
  logic [15:0] conflict_d;
  logic [15:0] forced_q;
  logic [15:0] forced_d;

  // Saturating event counters
  always_comb begin
    conflict_d = conflict_q;
    forced_d   = forced_q;
    if (both_req && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
    if (both_req && streak_full && forced_q != 16'hFFFF) begin
      forced_d = forced_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= 16'd0;
      forced_q   <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
      forced_q   <= forced_d;
    end
  end

  assign conflict_count = conflict_q;
  assign forced_count   = forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random
// phase against a transaction-level reference model and a behavioural RAM.
module tb_dmem_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wren;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_q;
  logic          acc_req, acc_wren;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          acc_gnt, acc_rvalid;
  logic [DW-1:0] acc_q;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_count, forced_count;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_STREAK(MAXS)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_stall(cpu_stall), .cpu_q(cpu_q),
    .cpu_rvalid(cpu_rvalid),
    .acc_req(acc_req), .acc_wren(acc_wren), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_gnt(acc_gnt), .acc_q(acc_q),
    .acc_rvalid(acc_rvalid),
`ifdef DMEM_ARB_STATS_EN
    .conflict_count(conflict_count), .forced_count(forced_count),
`endif
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always_ff @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  // reference model state
  logic [DW-1:0] mref [0:(1<<AW)-1];
  int            m_streak;
  int            m_owner;
  logic [DW-1:0] m_rdata;
  int            m_conf, m_forced;
  bit            last_gc, last_ga;
  logic          obs_stall, obs_agnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_owner  = 0;
    m_conf   = 0;
    m_forced = 0;
  endtask

  task automatic cyc();
    bit gc, ga, both;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            nown;
    @(negedge clock);
    both = cpu_req && acc_req;
    gc   = cpu_req && !(acc_req && m_streak == MAXS);
    ga   = acc_req && !gc;
    ew = 1'b0; ea = '0; ed = '0;
    if (gc) begin
      ew = cpu_wren; ea = cpu_addr; ed = cpu_data;
    end else if (ga) begin
      ew = acc_wren; ea = acc_addr; ed = acc_data;
    end
    obs_stall = cpu_stall;
    obs_agnt  = acc_gnt;
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !gc));
    chk("acc_gnt", 32'(acc_gnt), 32'(ga));
    chk("mem_wren", 32'(mem_wren), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_data", mem_data, ed);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_owner == 1));
    chk("acc_rvalid", 32'(acc_rvalid), 32'(m_owner == 2));
    if (m_owner == 1) chk("cpu_q", cpu_q, m_rdata);
    if (m_owner == 2) chk("acc_q", acc_q, m_rdata);
    nown = 0;
    if (gc) begin
      if (cpu_wren) mref[cpu_addr] = cpu_data;
      else begin nown = 1; m_rdata = mref[cpu_addr]; end
    end else if (ga) begin
      if (acc_wren) mref[acc_addr] = acc_data;
      else begin nown = 2; m_rdata = mref[acc_addr]; end
    end
    m_owner = nown;
    if (both && m_streak == MAXS && m_forced < 65535) m_forced++;
    if (both && m_conf < 65535) m_conf++;
    if (both && gc) m_streak++;
    else if (ga || !acc_req) m_streak = 0;
    last_gc = gc;
    last_ga = ga;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit cp, ap;
    reset = 1'b1;
    cpu_req = 0; cpu_wren = 0; cpu_addr = '0; cpu_data = '0;
    acc_req = 0; acc_wren = 0; acc_addr = '0; acc_data = '0;
    model_reset();
    #2;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_acc_rvalid", 32'(acc_rvalid), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // preload words 0..31 through CPU stores
    for (int i = 0; i < 32; i++) begin
      cpu_req = 1; cpu_wren = 1; cpu_addr = 12'(i);
      cpu_data = (i == 16) ? 32'hDEADBEEF : $urandom;
      cyc();
    end
    cpu_req = 0; cpu_wren = 0;

    // CPU-only load of 0x010
    cpu_req = 1; cpu_addr = 12'h010;
    cyc();
    chk("ld010_stall", 32'(obs_stall), 32'd0);
    cpu_req = 0;
    chk("ld010_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("ld010_q", cpu_q, 32'hDEADBEEF);
    chk("ld010_acc_rvalid", 32'(acc_rvalid), 32'd0);
    cyc();

    // ACC store then load of 0x020
    acc_req = 1; acc_wren = 1; acc_addr = 12'h020; acc_data = 32'h12345678;
    cyc();
    chk("acc_st_gnt", 32'(obs_agnt), 32'd1);
    acc_wren = 0;
    cyc();
    chk("acc_ld_gnt", 32'(obs_agnt), 32'd1);
    acc_req = 0;
    chk("acc_ld_rvalid", 32'(acc_rvalid), 32'd1);
    chk("acc_ld_q", acc_q, 32'h12345678);
    cyc();

    // continuous contention: CPU,CPU,CPU,CPU,ACC repeating
    cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h010;
    acc_req = 1; acc_wren = 0; acc_addr = 12'h020;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_pattern", 32'(obs_stall), 32'(i % 5 == 4));
    end
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_10", 32'(conflict_count), 32'd10);
    chk("forced_10", 32'(forced_count), 32'd2);
`endif
    cpu_req = 0; acc_req = 0;
    cyc();

    // same-cycle CPU store / ACC load to 0x030
    cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h030; cpu_data = 32'hA;
    acc_req = 1; acc_wren = 0; acc_addr = 12'h030;
    cyc();
    chk("same_cpu_win", 32'(obs_stall), 32'd0);
    cpu_req = 0; cpu_wren = 0;
    cyc();
    chk("same_acc_gnt", 32'(obs_agnt), 32'd1);
    acc_req = 0;
    chk("same_acc_rvalid", 32'(acc_rvalid), 32'd1);
    chk("same_acc_q", acc_q, 32'hA);
    cyc();

    // build a full streak ending in a CPU load, then reset
    cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h010;
    acc_req = 1; acc_wren = 0; acc_addr = 12'h020;
    for (int i = 0; i < MAXS; i++) cyc();
    chk("pre_rst_rvalid", 32'(cpu_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_drop_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_drop_acc_rvalid", 32'(acc_rvalid), 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    cyc();
    chk("post_rst_cpu_win", 32'(obs_stall), 32'd0);
    cpu_req = 0; acc_req = 0;
    cyc();

    // random phase with hold-until-granted requesters
    cp = 0; ap = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cp) begin
        cpu_req  = ($urandom_range(0, 9) < 6);
        cpu_wren = 1'($urandom_range(0, 1));
        cpu_addr = 12'($urandom_range(0, 31));
        cpu_data = $urandom;
        cp = cpu_req;
      end
      if (!ap) begin
        acc_req  = ($urandom_range(0, 9) < 6);
        acc_wren = 1'($urandom_range(0, 1));
        acc_addr = 12'($urandom_range(0, 31));
        acc_data = $urandom;
        ap = acc_req;
      end
      cyc();
      if (last_gc) begin cp = 0; cpu_req = 0; end
      if (last_ga) begin ap = 0; acc_req = 0; end
    end
    cpu_req = 0; acc_req = 0;
    cyc();
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_end", 32'(conflict_count), 32'(m_conf));
    chk("forced_end", 32'(forced_count), 32'(m_forced));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
